// File: rtl/past_notes_replay.sv
// Past-notes history capture and oldest-first replay engine.
// History shifts on note_en; replay plays a snapshot taken at start, holding each note for hold_cycles.
module past_notes_replay #(
  parameter int NOTE_W = 4,
  parameter int DEPTH  = 5,
  parameter int DUR_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              note_en,
  input  logic              replay_start,
  input  logic              abort,
  input  logic [DUR_W-1:0]  hold_cycles,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fill
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] FILL_MAX = 3'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t             state_reg;
  logic [NOTE_W-1:0]  hist_reg  [DEPTH];
  logic [NOTE_W-1:0]  hist_next [DEPTH];
  logic [NOTE_W-1:0]  snap_reg  [DEPTH];
  logic [2:0]         fill_reg;
  logic [2:0]         snap_fill_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   idx_dec;
  logic [IDX_W-1:0]   load_idx;
  logic [DUR_W-1:0]   timer_reg;
  logic [DUR_W-1:0]   dur_reg;
  logic [DUR_W-1:0]   dur_next;
  logic [NOTE_W-1:0]  note_out_reg;
  logic               note_valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               snap_take;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign hist_next[gi] = note_in;
      end else begin : g_body
        assign hist_next[gi] = hist_reg[gi-1];
      end
    end
  endgenerate

  // Snapshot is taken from pre-write history, so a same-cycle append is not replayed.
  assign snap_take = (state_reg == S_IDLE) && replay_start;
  assign dur_next  = (hold_cycles == '0) ? DUR_W'(1) : hold_cycles;
  assign idx_dec   = idx_reg - IDX_W'(1);
  assign load_idx  = IDX_W'(snap_fill_reg - 3'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_reg[i] <= '0;
        snap_reg[i] <= '0;
      end
      fill_reg      <= '0;
      snap_fill_reg <= '0;
    end else begin
      if (snap_take) begin
        for (int i = 0; i < DEPTH; i++) snap_reg[i] <= hist_reg[i];
        snap_fill_reg <= fill_reg;
      end
      if (note_en) begin
        for (int i = 0; i < DEPTH; i++) hist_reg[i] <= hist_next[i];
        if (fill_reg != FILL_MAX) fill_reg <= fill_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      timer_reg      <= '0;
      dur_reg        <= '0;
      note_out_reg   <= '0;
      note_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (replay_start) begin
            dur_reg <= dur_next;
            if (fill_reg != 3'd0) begin
              state_reg <= S_LOAD;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            idx_reg        <= load_idx;
            timer_reg      <= dur_reg - DUR_W'(1);
            note_out_reg   <= snap_reg[load_idx];
            note_valid_reg <= 1'b1;
            state_reg      <= S_PLAY;
          end
        end
        S_PLAY: begin
          // Abort wins over a simultaneous timer expiry.
          if (abort) begin
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
            note_valid_reg <= 1'b0;
          end else if (timer_reg == '0) begin
            if (idx_reg != '0) begin
              idx_reg      <= idx_dec;
              timer_reg    <= dur_reg - DUR_W'(1);
              note_out_reg <= snap_reg[idx_dec];
            end else begin
              state_reg      <= S_DONE;
              done_reg       <= 1'b1;
              busy_reg       <= 1'b0;
              note_valid_reg <= 1'b0;
            end
          end else begin
            timer_reg <= timer_reg - DUR_W'(1);
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign note_out   = note_out_reg;
  assign note_valid = note_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign fill       = fill_reg;

endmodule

// File: tb/tb_past_notes_replay.sv
// Directed bench for past_notes_replay: capture, replay timing, abort, reset and start filtering.
module tb_past_notes_replay;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  note_in;
  logic        note_en;
  logic        replay_start;
  logic        abort;
  logic [10:0] hold_cycles;
  logic [3:0]  note_out;
  logic        note_valid;
  logic        busy;
  logic        done;
  logic [2:0]  fill;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_notes [5];

  always #5 clk = ~clk;

  past_notes_replay #(.NOTE_W(4), .DEPTH(5), .DUR_W(11)) dut (
    .clk(clk), .reset(reset), .note_in(note_in), .note_en(note_en),
    .replay_start(replay_start), .abort(abort), .hold_cycles(hold_cycles),
    .note_out(note_out), .note_valid(note_valid), .busy(busy), .done(done),
    .fill(fill)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic write_note(input logic [3:0] v);
    note_en = 1'b1;
    note_in = v;
    step();
    note_en = 1'b0;
  endtask

  // Start a replay and check LOAD, every PLAY cycle, the done pulse and the return to idle.
  task automatic do_replay(input int n, input int d, input logic [10:0] h);
    replay_start = 1'b1;
    hold_cycles  = h;
    step();
    replay_start = 1'b0;
    if (n == 0) begin
      check("empty_done",  32'(done), 32'd1);
      check("empty_busy",  32'(busy), 32'd0);
      check("empty_valid", 32'(note_valid), 32'd0);
    end else begin
      check("load_busy",  32'(busy), 32'd1);
      check("load_valid", 32'(note_valid), 32'd0);
      for (int k = 0; k < n; k++) begin
        for (int c = 0; c < d; c++) begin
          step();
          check("play_valid", 32'(note_valid), 32'd1);
          check("play_note",  32'(note_out), 32'(exp_notes[k]));
          check("play_busy",  32'(busy), 32'd1);
          check("play_done",  32'(done), 32'd0);
        end
      end
      step();
      check("end_done",  32'(done), 32'd1);
      check("end_busy",  32'(busy), 32'd0);
      check("end_valid", 32'(note_valid), 32'd0);
    end
    step();
    check("after_done", 32'(done), 32'd0);
    check("after_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    reset = 1'b0; note_in = '0; note_en = 1'b0; replay_start = 1'b0;
    abort = 1'b0; hold_cycles = '0;
    @(negedge clk);

    // Reset state, then saturating capture and full replay at hold 3
    do_reset();
    check("rst_note",  32'(note_out), 32'd0);
    check("rst_valid", 32'(note_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_fill",  32'(fill), 32'd0);
    write_note(4'd4); write_note(4'd5); write_note(4'd9);
    write_note(4'd10); write_note(4'd14); write_note(4'd8);
    check("fill_sat", 32'(fill), 32'd5);
    exp_notes = '{4'd5, 4'd9, 4'd10, 4'd14, 4'd8};
    do_replay(5, 3, 11'd3);

    // Empty history: done the next cycle, never busy
    do_reset();
    do_replay(0, 0, 11'd3);

    // hold_cycles 0 behaves as 1
    do_reset();
    write_note(4'd3); write_note(4'd1);
    check("fill_two", 32'(fill), 32'd2);
    exp_notes[0] = 4'd3; exp_notes[1] = 4'd1;
    do_replay(2, 1, 11'd0);

    // Writes during replay (including the start cycle) do not disturb the snapshot
    do_reset();
    write_note(4'd4); write_note(4'd6); write_note(4'd15);
    exp_notes[0] = 4'd4; exp_notes[1] = 4'd6; exp_notes[2] = 4'd15;
    note_en = 1'b1; note_in = 4'd2;
    do_replay(3, 2, 11'd2);
    note_en = 1'b0;
    check("fill_after_writes", 32'(fill), 32'd5);
    exp_notes = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    do_replay(5, 1, 11'd1);

    // Abort on the 13th PLAY cycle, then a fresh start is accepted
    do_reset();
    for (int v = 1; v <= 5; v++) write_note(4'(v));
    replay_start = 1'b1; hold_cycles = 11'd10;
    step();
    replay_start = 1'b0;
    check("abort_load_busy", 32'(busy), 32'd1);
    for (int p = 1; p <= 13; p++) begin
      step();
      check("abort_play_valid", 32'(note_valid), 32'd1);
      check("abort_play_note",  32'(note_out), (p <= 10) ? 32'd1 : 32'd2);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(note_valid), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_done",  32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", 32'(done), 32'd0);
    end
    exp_notes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    do_replay(5, 1, 11'd1);

    // Reset mid-PLAY clears everything with no done pulse
    replay_start = 1'b1; hold_cycles = 11'd10;
    step();
    replay_start = 1'b0;
    step(); step();
    check("pre_rst_valid", 32'(note_valid), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_note",  32'(note_out), 32'd0);
    check("midrst_valid", 32'(note_valid), 32'd0);
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_done",  32'(done), 32'd0);
    check("midrst_fill",  32'(fill), 32'd0);
    step();
    check("midrst_no_done", 32'(done), 32'd0);

    // Starts while busy or in DONE are ignored
    do_reset();
    write_note(4'd7); write_note(4'd8);
    replay_start = 1'b1; hold_cycles = 11'd2;
    step();
    busy_cnt = 0;
    done_cnt = 0;
    for (int t = 1; t <= 12; t++) begin
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (t == 3) check("busy_start_note", 32'(note_out), 32'd7);
      if (t == 6) check("busy_start_done", 32'(done), 32'd1);
      replay_start = (t == 2 || t == 6);
      step();
    end
    replay_start = 1'b0;
    check("ignored_busy_cycles", 32'(busy_cnt), 32'd5);
    check("ignored_done_count",  32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/past_notes_replay.md
Name: past_notes_replay

Overview:
- Reader/player end of the past-notes history.
- Captures the last DEPTH notes from the note stream using the same shift-on-enable scheme as the history flops: newest in slot 0, older notes shifting down.
- On request, replays the captured notes oldest-first, holding each note for a programmed number of cycles, then reports completion.
- Sits between the note-history writer and the note player/codec front end.

Parameters:
NOTE_W, 4, width of one note code
DEPTH, 5, number of history slots (>=1)
DUR_W, 11, width of per-note hold count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset asserted)
note_in  input  NOTE_W  note to append to history
note_en  input  1  append strobe (new_notes && play_enable upstream)
replay_start  input  1  one-cycle request to begin replay
abort  input  1  stop replay immediately
hold_cycles  input  DUR_W  cycles each note is held during replay
note_out  output  NOTE_W  note being replayed
note_valid  output  1  note_out is a live replay note
busy  output  1  replay in progress (LOAD/PLAY)
done  output  1  one-cycle pulse at replay end (normal or empty)
fill  output  3  valid history entries, saturating at DEPTH

Behaviour:
- Reset (reset==0 at clk edge): all history slots 0, fill 0, state IDLE, note_out 0, note_valid 0, busy 0, done 0, timer 0, index 0. Reset mid-replay aborts with no done pulse.
- History write, active in every state:
  - When note_en=1: hist[0]<=note_in, hist[i]<=hist[i-1] for i=1..DEPTH-1; fill<=min(fill+1, DEPTH).
  - fill saturates and never wraps.
- Replay snapshot:
  - On accepted replay_start, copy hist[] and fill into a private replay buffer.
  - Writes during replay update history only and do not change the note sequence being played.
  - If note_en and replay_start occur in the same cycle, the snapshot takes pre-write contents.
- Effective hold: dur = (hold_cycles==0) ? 1 : hold_cycles, sampled at start.
- States:
  - IDLE: busy=0, note_valid=0. replay_start with fill>0 -> LOAD. replay_start with fill==0 -> DONE.
  - LOAD (1 cycle): busy=1, note_valid=0. idx<=snap_fill-1, timer<=dur-1 -> PLAY.
  - PLAY: busy=1, note_valid=1, note_out=snap[idx].
    - Timer decrements each cycle.
    - On timer==0 with idx>0: idx<=idx-1, timer<=dur-1.
    - On timer==0 with idx==0: -> DONE.
  - DONE (1 cycle): done=1, busy=0, note_valid=0 -> IDLE.
- Latency:
  - First note_valid appears 2 cycles after the replay_start edge.
  - Each note is valid for exactly dur cycles.
  - done asserts the cycle after the last note's final cycle.
- replay_start while busy or in DONE is ignored; there is no queueing.
- abort in LOAD/PLAY: next state IDLE, note_valid=0, busy=0, no done pulse. abort in IDLE/DONE has no effect. abort has priority over timer expiry in the same cycle.
- note_out holds its last value when note_valid=0; consumers gate on note_valid.
- Timer is DUR_W wide and never underflows; all-ones hold_cycles plays 2^DUR_W-1 cycles per note.

Test Plan:
- Reset, then write 4,5,9,10,14,8 on consecutive cycles; replay_start with hold_cycles=3 -> fill saturates at 5; note_out sequence 5,9,10,14,8 with each note valid 3 cycles, first valid 2 cycles after start; done 1-cycle pulse after 15 valid cycles; busy low in the done cycle.
- Reset, then replay_start with no writes -> no note_valid; done pulses the next cycle; busy never asserts.
- Write 3,1; start with hold_cycles=0 -> notes 3 then 1, one cycle each; done follows.
- Write 4,6,15; start with hold_cycles=2; during play write 2 every cycle -> replay still 4,6,15; afterwards fill=5 and newest slot holds 2.
- Start replay of 5 notes with hold_cycles=10; assert abort on the 13th PLAY cycle -> note_valid/busy low next cycle, no done; a new replay_start is then accepted. Repeat with reset driven to 0 mid-PLAY -> all outputs 0 and fill 0.
- Second replay_start pulses while busy -> ignored; exactly one done pulse per accepted start.
